// File: rtl/led_pkg.sv
// Shared definitions for the LED digit scanner: segment layout,
// hex glyph table and scan state encoding.
package led_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int DP_BIT = 7;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_t;

    // Active-high g..a pattern for one hex digit
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_digit_scanner_timer.sv
// Dwell counter for the scanner: times the lit phase and the
// blanking gap of each digit and flags their last cycle.
module led_scan_timer
    import led_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter int GAP_CYCLES  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in_show,
    input  logic in_gap,
    output logic show_done,
    output logic gap_done
);

    localparam int MAXC = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [CW-1:0] div_cnt;
    logic          gap_en;

    assign gap_en    = (GAP_CYCLES > 0);
    assign show_done = in_show && (div_cnt == SHOW_LAST);
    assign gap_done  = gap_en && in_gap && (div_cnt == GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clear || show_done || gap_done || !(in_show || in_gap)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_digit_scanner.sv
// Time-multiplexed 7-segment scan controller with double-buffered
// value, blanking gaps and leading-zero suppression.
module led_digit_scanner
    import led_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int REFRESH_DIV   = 1000,
    parameter int GAP_CYCLES    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [7:0]            dec_in,
    input  logic [7:0]            dec_out,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int VW = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

    scan_state_t       state, state_n;
    logic [IW-1:0]     idx, idx_n, next_idx;
    logic              wrap, swap;
    logic              show_done, gap_done;
    logic [VW-1:0]     active, shadow, upper;
    logic [DIGITS-1:0] dp_active, dp_shadow;
    logic              pending;
    logic [3:0]        nibble;
    logic              blank;

    led_scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (!enable || (state == ST_OFF)),
        .in_show   (state == ST_SHOW),
        .in_gap    (state == ST_GAP),
        .show_done (show_done),
        .gap_done  (gap_done)
    );

    assign nibble   = active[{idx, 2'b00} +: 4];
    assign dec_in   = {4'b0000, nibble};
    assign upper    = active >> {idx, 2'b00};
    assign blank    = (BLANK_LEADING != 0) && (idx != '0) && (upper == '0);
    assign wrap     = (idx == LAST_IDX);
    assign next_idx = wrap ? '0 : idx + 1'b1;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        swap    = 1'b0;
        if (!enable) begin
            state_n = ST_OFF;
            idx_n   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_n = ST_SHOW;
                    idx_n   = '0;
                    swap    = 1'b1;
                end
                ST_SHOW: begin
                    if (show_done) begin
                        if (GAP_CYCLES > 0) begin
                            state_n = ST_GAP;
                        end else begin
                            idx_n = next_idx;
                            swap  = wrap;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state_n = ST_SHOW;
                        idx_n   = next_idx;
                        swap    = wrap;
                    end
                end
                default: begin
                    state_n = ST_OFF;
                    idx_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // A swap reads the pre-edge shadow; a coincident load stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= '0;
            dp_active <= '0;
            shadow    <= '0;
            dp_shadow <= '0;
            pending   <= 1'b0;
        end else begin
            if (swap && pending) begin
                active    <= shadow;
                dp_active <= dp_shadow;
            end
            if (load) begin
                shadow    <= value_in;
                dp_shadow <= dp_in;
                pending   <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= '0;
            digit_sel  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= swap;
            if (state == ST_SHOW) begin
                digit_sel <= ONE_HOT0 << idx;
                seg       <= {dp_active[idx], blank ? 7'h00 : dec_out[6:0]};
            end else begin
                digit_sel <= '0;
                seg       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_digit_scanner.sv
// Directed bench for led_digit_scanner: a frame-timeline model checked
// every cycle, plus hand-computed literal expectations.
module tb_led_digit_scanner;
    import led_pkg::*;

    localparam int D = 4;
    localparam int R = 4;
    localparam int G = 1;
    localparam int SLOT = R + G;
    localparam int PERIOD = D * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;

    logic [7:0]  dec_in_a, dec_out_a, seg_a;
    logic [3:0]  sel_a;
    logic        fd_a;
    logic [7:0]  dec_in_b, dec_out_b, seg_b;
    logic [3:0]  sel_b;
    logic        fd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External decoder; bit 7 driven high to prove it is ignored
    assign dec_out_a = {1'b1, hex_seg(dec_in_a[3:0])};
    assign dec_out_b = {1'b1, hex_seg(dec_in_b[3:0])};

    led_digit_scanner #(
        .DIGITS(D), .REFRESH_DIV(R), .GAP_CYCLES(G), .BLANK_LEADING(1)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .value_in(value_in),
        .dp_in(dp_in), .load(load), .dec_in(dec_in_a),
        .dec_out(dec_out_a), .seg(seg_a), .digit_sel(sel_a),
        .frame_done(fd_a)
    );

    led_digit_scanner #(
        .DIGITS(D), .REFRESH_DIV(R), .GAP_CYCLES(G), .BLANK_LEADING(0)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .value_in(value_in),
        .dp_in(dp_in), .load(load), .dec_in(dec_in_b),
        .dec_out(dec_out_b), .seg(seg_b), .digit_sel(sel_b),
        .frame_done(fd_b)
    );

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: position t within the frame timeline, plus the two buffers
    bit          m_on = 0;
    int          m_t = 0;
    logic [15:0] m_active = '0, m_shadow = '0;
    logic [3:0]  m_dpa = '0, m_dps = '0;
    bit          m_pend = 0;
    logic [7:0]  e_seg_a = '0, e_seg_b = '0;
    logic [3:0]  e_sel = '0;
    logic        e_fd = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_on = 0; m_t = 0; m_pend = 0;
            m_active = '0; m_shadow = '0; m_dpa = '0; m_dps = '0;
            e_seg_a = '0; e_seg_b = '0; e_sel = '0; e_fd = 0;
        end else begin
            int  d;
            bit  allz, swp;
            logic [3:0] nib;
            logic [6:0] pat;
            e_seg_a = '0; e_seg_b = '0; e_sel = '0;
            if (m_on && (m_t % SLOT) < R) begin
                d = m_t / SLOT;
                nib = m_active[4*d +: 4];
                pat = hex_seg(nib);
                allz = 1;
                for (int k = d; k < D; k++)
                    if (m_active[4*k +: 4] != 4'h0) allz = 0;
                e_sel = 4'(1 << d);
                e_seg_a = {m_dpa[d], (d != 0 && allz) ? 7'h00 : pat};
                e_seg_b = {m_dpa[d], pat};
            end
            swp = 0;
            if (!enable) begin
                m_on = 0;
            end else if (!m_on) begin
                m_on = 1; m_t = 0; swp = 1;
            end else begin
                m_t++;
                if (m_t == PERIOD) begin
                    m_t = 0; swp = 1;
                end
            end
            e_fd = swp;
            if (swp && m_pend) begin
                m_active = m_shadow; m_dpa = m_dps; m_pend = 0;
            end
            if (load) begin
                m_shadow = value_in; m_dps = dp_in; m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_seg_a", seg_a, e_seg_a);
        chk("model_sel_a", {4'h0, sel_a}, {4'h0, e_sel});
        chk("model_fd_a", {7'h0, fd_a}, {7'h0, e_fd});
        chk("model_seg_b", seg_b, e_seg_b);
        chk("model_sel_b", {4'h0, sel_b}, {4'h0, e_sel});
        chk("model_fd_b", {7'h0, fd_b}, {7'h0, e_fd});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [3:0] sel,
                       input logic [7:0] sg);
        chk({name, "_sel"}, {4'h0, sel_a}, {4'h0, sel});
        chk({name, "_seg"}, seg_a, sg);
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        // Idle after reset
        step(3);
        lit("idle", 4'h0, 8'h00);
        chk("idle_fd", {7'h0, fd_a}, 8'h00);

        // Scan order with 0x1234
        value_in = 16'h1234; dp_in = 4'h0; load = 1'b1;
        step(1);
        load = 1'b0; enable = 1'b1;
        step(1);
        chk("start_fd", {7'h0, fd_a}, 8'h01);
        lit("start_off", 4'h0, 8'h00);
        step(1);  lit("scan_d0", 4'h1, 8'h66);
        step(5);  lit("scan_d1", 4'h2, 8'h4F);
        step(5);  lit("scan_d2", 4'h4, 8'h5B);
        step(5);  lit("scan_d3", 4'h8, 8'h06);
        step(4);
        chk("frame2_fd", {7'h0, fd_a}, 8'h01);

        // Tear-free: load 0xABCD while digit 2 is lit
        step(10);
        value_in = 16'hABCD; load = 1'b1;
        step(1);
        load = 1'b0;
        lit("tear_d2", 4'h4, 8'h5B);
        step(5);  lit("tear_d3", 4'h8, 8'h06);
        step(5);  lit("new_d0", 4'h1, 8'h5E);
        step(5);  lit("new_d1", 4'h2, 8'h39);
        step(5);  lit("new_d2", 4'h4, 8'h7C);
        step(5);  lit("new_d3", 4'h8, 8'h77);

        // Load coincident with a frame swap lands one frame later
        step(23);
        value_in = 16'h0070; load = 1'b1;
        step(1);
        load = 1'b0;
        chk("coin_fd", {7'h0, fd_a}, 8'h01);
        step(1);  lit("coin_old", 4'h1, 8'h5E);
        step(20); lit("lz_d0", 4'h1, 8'h3F);
        step(5);  lit("lz_d1", 4'h2, 8'h07);
        step(5);  lit("lz_d2", 4'h4, 8'h00);
        chk("nb_d2", seg_b, 8'h3F);
        step(5);  lit("lz_d3", 4'h8, 8'h00);

        // All zero with dp on digit 2
        value_in = 16'h0000; dp_in = 4'b0100; load = 1'b1;
        step(1);
        load = 1'b0;
        step(4);  lit("z_d0", 4'h1, 8'h3F);
        step(5);  lit("z_d1", 4'h2, 8'h00);
        step(5);  lit("z_d2dp", 4'h4, 8'h80);
        chk("nb_d2dp", seg_b, 8'hBF);
        step(5);  lit("z_d3", 4'h8, 8'h00);

        // Enable drop mid-show
        enable = 1'b0;
        step(1);  lit("drop_e1", 4'h8, 8'h00);
        step(1);  lit("drop_e2", 4'h0, 8'h00);
        step(3);  lit("drop_hold", 4'h0, 8'h00);
        enable = 1'b1;
        step(1);
        chk("reen_fd", {7'h0, fd_a}, 8'h01);
        step(1);  lit("reen_d0", 4'h1, 8'h3F);

        // Async reset during the gap, off the clock edge
        step(3);
        lit("pre_rst", 4'h1, 8'h3F);
        #2 rst = 1'b1;
        #1;
        lit("async_rst", 4'h0, 8'h00);
        chk("async_fd", {7'h0, fd_a}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("post_fd", {7'h0, fd_a}, 8'h01);
        step(1);  lit("post_d0", 4'h1, 8'h3F);
        step(25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
